rand_roll_history: RTL
======================

# rand_roll_history

Parametrised random-number roll engine with a recallable result history, the successor to the lab's single-value random generator core. It sits between the debounced key pulses and the seven-segment decoders. A start pulse runs a decelerating roll animation driven by a free-running LFSR and commits the final value into a DEPTH-entry ring buffer. A recall pulse steps the display output back through previous results.

## Interface
- WIDTH, 4: output value width, 1..16
- DEPTH, 8: history entries, power of 2, ≥2
- ROLL_STEPS, 16: displayed updates per roll, ≥1
- BASE_PERIOD, 1_000_000: cycles before the first update; gap k is k*BASE_PERIOD, ≥1
- SEED, 16'hACE1: LFSR reset value, nonzero
- i_clk  in  1  system clock; all logic on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  one-cycle start pulse from debounce
- i_recall  in  1  one-cycle pulse, step history index back by one
- o_random_out  out  WIDTH  current roll / last result
- o_history_out  out  WIDTH  history entry at o_history_idx
- o_history_idx  out  $clog2(DEPTH)  0 = most recent commit
- o_busy  out  1  high while rolling
- o_done  out  1  one-cycle pulse on commit

## Operation
- LFSR: 16-bit Galois, advances every cycle regardless of state: lfsr <= (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0).
- FSM states: IDLE and ROLL.
- IDLE -> ROLL on i_start. Load cnt=BASE_PERIOD-1, reload=BASE_PERIOD, step=0.
- ROLL: cnt decrements each cycle. When cnt==0:
  - o_random_out <= lfsr[WIDTH-1:0], step++.
  - reload <= reload+BASE_PERIOD; cnt <= reload+BASE_PERIOD-1.
- Size cnt/reload to hold BASE_PERIOD*ROLL_STEPS. No overflow is permitted.
- Final update (step reaches ROLL_STEPS):
  - mem[wr_ptr] <= value; wr_ptr++ (wraps mod DEPTH).
  - count <= min(count+1, DEPTH); idx <= 0.
  - o_done=1 for one cycle; -> IDLE.
- i_start while in ROLL restarts the roll: counters reloaded as from IDLE, no commit, o_random_out keeps its last value.
- Recall:
  - i_recall at any state sets idx <= (idx+1 == count) ? 0 : idx+1.
  - i_recall is ignored when count==0.
- o_history_out = mem[(wr_ptr-1-idx) mod DEPTH] when count>0, else 0. Combinational from registers.
- Simultaneous commit and i_recall: commit wins, idx=0.
- Full buffer: the oldest entry is overwritten and count stays at DEPTH.

## Timing
- Reset (async assert, sync deassert externally assumed by board):
  - o_random_out=0, o_history_out=0, o_history_idx=0, o_busy=0, o_done=0.
  - mem all 0, wr_ptr=0, count=0, lfsr=SEED, state IDLE.
- o_busy rises the cycle after the i_start edge and falls on the edge after the commit.
- Update k occurs BASE_PERIOD*k*(k+1)/2 cycles after the accepting start edge.
- o_done coincides with the final o_random_out update. The new history entry is visible at o_history_out in that same cycle.
- Recall latency: idx and o_history_out change one edge after the i_recall edge.
- Reset mid-roll aborts immediately: no commit, and all state returns to reset values.

## Test plan
- Reset with SEED=16'hACE1 -> lfsr 16'hACE1, then 16'hE270, then 16'h7138 on successive edges; all outputs 0.
- BASE_PERIOD=2, ROLL_STEPS=3, i_start at edge 0:
  - updates at edges 2, 6, 12; o_done only at edge 12.
  - o_busy high during edges 1..12; history[0]=o_random_out.
- i_start at edge 4 of that roll:
  - updates resume at edges 6, 10, 16; exactly one commit.
- DEPTH=4, five rolls with results r1..r5:
  - count=4; idx 0..3 shows r5, r4, r3, r2.
  - a fourth recall wraps idx to 0 (r5).
- i_recall with count==0 -> idx stays 0, o_history_out=0.
- i_recall on the commit edge -> idx=0 and the new value is shown.
- i_rst_n low mid-roll -> o_busy=0, count=0, no o_done.
- i_rst_n low mid-roll, then a fresh start -> the roll completes normally.

Source files
------------

// File: rtl/rand_roll_history.sv
// Random roll engine: a free-running LFSR feeds a decelerating roll animation,
// and each final value is committed into a recallable ring-buffer history.
module rand_roll_history #(
  parameter int          WIDTH       = 4,
  parameter int          DEPTH       = 8,
  parameter int          ROLL_STEPS  = 16,
  parameter int          BASE_PERIOD = 1_000_000,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic                     i_recall,
  output logic [WIDTH-1:0]         o_random_out,
  output logic [WIDTH-1:0]         o_history_out,
  output logic [$clog2(DEPTH)-1:0] o_history_idx,
  output logic                     o_busy,
  output logic                     o_done
);

  localparam int CW = $clog2(BASE_PERIOD * ROLL_STEPS + 1);
  localparam int SW = $clog2(ROLL_STEPS + 1);
  localparam int IW = $clog2(DEPTH);
  localparam int NW = $clog2(DEPTH + 1);

  typedef enum logic {IDLE, ROLL} state_t;

  state_t            state, state_next;
  logic [15:0]       lfsr;
  logic [CW-1:0]     cnt, cnt_next;
  logic [CW-1:0]     reload, reload_next;
  logic [SW-1:0]     step, step_next;
  logic              update, commit;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [IW-1:0]     wr_ptr;
  logic [IW-1:0]     rd_ptr;
  logic [NW-1:0]     count;
  logic [IW-1:0]     idx;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_next;
  end

  // A start pulse restarts the roll from any state and suppresses that cycle's update.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    reload_next = reload;
    step_next   = step;
    update      = 1'b0;
    commit      = 1'b0;
    if (i_start) begin
      state_next  = ROLL;
      cnt_next    = CW'(BASE_PERIOD - 1);
      reload_next = CW'(BASE_PERIOD);
      step_next   = '0;
    end else if (state == ROLL) begin
      if (cnt == '0) begin
        update    = 1'b1;
        step_next = step + 1'b1;
        if (step_next == SW'(ROLL_STEPS)) begin
          commit     = 1'b1;
          state_next = IDLE;
        end else begin
          reload_next = reload + CW'(BASE_PERIOD);
          cnt_next    = reload + CW'(BASE_PERIOD) - 1'b1;
        end
      end else begin
        cnt_next = cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lfsr         <= SEED;
      cnt          <= '0;
      reload       <= '0;
      step         <= '0;
      o_random_out <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      wr_ptr       <= '0;
      count        <= '0;
      idx          <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      lfsr   <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      cnt    <= cnt_next;
      reload <= reload_next;
      step   <= step_next;
      // Busy lingers through the done cycle so it drops on the edge after commit.
      o_busy <= (state_next == ROLL) | commit;
      o_done <= commit;
      if (update) o_random_out <= lfsr[WIDTH-1:0];
      if (commit) begin
        mem[wr_ptr] <= lfsr[WIDTH-1:0];
        wr_ptr      <= wr_ptr + 1'b1;
        if (count != NW'(DEPTH)) count <= count + 1'b1;
        idx <= '0;
      end else if (i_recall && count != '0) begin
        idx <= ((NW'(idx) + 1'b1) == count) ? '0 : idx + 1'b1;
      end
    end
  end

  assign rd_ptr        = wr_ptr - 1'b1 - idx;
  assign o_history_idx = idx;

  always_comb begin
    o_history_out = '0;
    if (count != '0) o_history_out = mem[rd_ptr];
  end

endmodule
